// File: rtl/load_store_align_unit.sv
// Load/store byte-lane unit: aligned memory access, lane select with sign/zero extension,
// read-modify-write for sub-word stores, misalignment and read-timeout detection.
module load_store_align_unit #(
  parameter int XLEN       = 64,
  parameter int ADDR_W     = 64,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic [1:0]        rsp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(RD_TIMEOUT + 1);
  localparam logic [1:0]      FULL_SZ = (XLEN == 64) ? 2'd3 : 2'd2;
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZEROS   = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t state_r, state_nx_s;

  logic [CNTW-1:0]   cnt_r;
  logic              store_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [OFFW-1:0]   off_r;
  logic [XLEN-1:0]   wdata_r;

  logic              req_ready_r, mem_rd_r, mem_wr_r, rsp_valid_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [XLEN-1:0]   mem_wdata_r, rsp_data_r;
  logic [1:0]        rsp_err_r;

  logic              req_ready_nx_s, mem_rd_nx_s, mem_wr_nx_s, rsp_valid_nx_s;
  logic [ADDR_W-1:0] mem_addr_nx_s;
  logic [XLEN-1:0]   mem_wdata_nx_s, rsp_data_nx_s;
  logic [1:0]        rsp_err_nx_s;

  logic              accept_s, misal_s, full_store_s, timeout_s, sign_s;
  logic [OFFW-1:0]   req_off_s;
  logic [ADDR_W-1:0] aligned_s;
  logic [OFFW+2:0]   shift_s;
  logic [XLEN-1:0]   sh_s, keep_s, mask_s, ext_s, merged_s;

  // Request decode: acceptance, misalignment, aligned address
  always_comb begin
    req_off_s    = req_addr[OFFW-1:0];
    aligned_s    = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    accept_s     = req_valid & (state_r == ST_IDLE);
    full_store_s = req_store & (req_size == FULL_SZ);
    case (req_size)
      2'd0:    misal_s = 1'b0;
      2'd1:    misal_s = req_off_s[0];
      2'd2:    misal_s = |req_off_s[1:0];
      default: misal_s = (XLEN == 32) ? 1'b1 : |req_off_s;
    endcase
    timeout_s = (cnt_r == CNTW'(RD_TIMEOUT - 1)) & ~mem_rvalid;
  end

  // Lane math on the fetched word: extended load value and merged store word
  always_comb begin
    shift_s = {off_r, 3'b000};
    sh_s    = mem_rdata >> shift_s;
    case (size_r)
      2'd0: begin
        keep_s = ONES >> (XLEN - 8);
        sign_s = sh_s[7];
      end
      2'd1: begin
        keep_s = ONES >> (XLEN - 16);
        sign_s = sh_s[15];
      end
      2'd2: begin
        keep_s = ONES >> (XLEN - 32);
        sign_s = sh_s[31];
      end
      default: begin
        keep_s = ONES;
        sign_s = 1'b0;
      end
    endcase
    // Upper bits come from the sign only for signed sub-width loads
    ext_s    = (sh_s & keep_s) | ((sign_s & ~uns_r) ? ~keep_s : ZEROS);
    mask_s   = keep_s << shift_s;
    merged_s = (mem_rdata & ~mask_s) | ((wdata_r << shift_s) & mask_s);
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_nx_s = ST_IDLE;
        end else if (misal_s) begin
          state_nx_s = ST_RESP;
        end else if (full_store_s) begin
          state_nx_s = ST_WRITE;
        end else begin
          state_nx_s = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) begin
          state_nx_s = store_r ? ST_WRITE : ST_RESP;
        end else if (timeout_s) begin
          state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_RD_WAIT;
        end
      end
      ST_WRITE: state_nx_s = ST_RESP;
      ST_RESP:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on the state being entered
  always_comb begin
    req_ready_nx_s = (state_nx_s == ST_IDLE);
    mem_rd_nx_s    = 1'b0;
    mem_wr_nx_s    = 1'b0;
    mem_wdata_nx_s = ZEROS;
    rsp_valid_nx_s = 1'b0;
    rsp_data_nx_s  = ZEROS;
    rsp_err_nx_s   = 2'b00;
    if (accept_s && !misal_s) begin
      mem_addr_nx_s = aligned_s;
    end else begin
      mem_addr_nx_s = mem_addr_r;
    end
    case (state_nx_s)
      ST_RD_WAIT: mem_rd_nx_s = (state_r == ST_IDLE);
      ST_WRITE: begin
        mem_wr_nx_s = 1'b1;
        if (state_r == ST_IDLE) begin
          mem_wdata_nx_s = req_wdata;
        end else begin
          mem_wdata_nx_s = merged_s;
        end
      end
      ST_RESP: begin
        rsp_valid_nx_s = 1'b1;
        if (state_r == ST_IDLE) begin
          rsp_err_nx_s = 2'b01;
        end else if ((state_r == ST_RD_WAIT) && !mem_rvalid) begin
          rsp_err_nx_s = 2'b10;
        end else begin
          rsp_err_nx_s = 2'b00;
        end
        if ((state_r == ST_RD_WAIT) && mem_rvalid && !store_r) begin
          rsp_data_nx_s = ext_s;
        end else begin
          rsp_data_nx_s = ZEROS;
        end
      end
      default: begin
        mem_rd_nx_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_ready_r <= 1'b1;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= ZEROS;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= ZEROS;
      rsp_err_r   <= 2'b00;
    end else begin
      req_ready_r <= req_ready_nx_s;
      mem_rd_r    <= mem_rd_nx_s;
      mem_wr_r    <= mem_wr_nx_s;
      mem_addr_r  <= mem_addr_nx_s;
      mem_wdata_r <= mem_wdata_nx_s;
      rsp_valid_r <= rsp_valid_nx_s;
      rsp_data_r  <= rsp_data_nx_s;
      rsp_err_r   <= rsp_err_nx_s;
    end
  end

  // Request field capture on acceptance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      store_r <= 1'b0;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      off_r   <= {OFFW{1'b0}};
      wdata_r <= ZEROS;
    end else if (accept_s) begin
      store_r <= req_store;
      size_r  <= req_size;
      uns_r   <= req_unsigned | (req_size == 2'd3);
      off_r   <= req_off_s;
      wdata_r <= req_wdata;
    end else begin
      store_r <= store_r;
      size_r  <= size_r;
      uns_r   <= uns_r;
      off_r   <= off_r;
      wdata_r <= wdata_r;
    end
  end

  // Read-wait cycle counter, restarted on every entry to the wait state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNTW{1'b0}};
    end else if ((state_r == ST_RD_WAIT) && (state_nx_s == ST_RD_WAIT)) begin
      cnt_r <= cnt_r + CNTW'(1);
    end else begin
      cnt_r <= {CNTW{1'b0}};
    end
  end

  assign req_ready = req_ready_r;
  assign mem_rd    = mem_rd_r;
  assign mem_wr    = mem_wr_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

endmodule
